// File: rtl/fc_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : fc_result_reader
// Brief    : Reads the FC2 class scores from SRAM f after fc2_done and
//            reports the signed argmax on a valid/ready result port.
//            Optional runner-up tracking is enabled by FC_RESULT_SECOND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fc_result_reader #(
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    parameter int NUM_CLASS              = 10,
    parameter int ADDR_WIDTH             = 10
) (
    input  logic                                         clk,
    input  logic                                         srstn,
    input  logic                                         fc2_done,
    output logic [ADDR_WIDTH-1:0]                        sram_raddr_f,
    input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata_f,
    output logic                                         busy,
    output logic                                         result_valid,
    input  logic                                         result_ready,
    output logic [3:0]                                   result_class,
    output logic [DATA_WIDTH-1:0]                        result_score
`ifdef FC_RESULT_SECOND_EN
    ,
    output logic [3:0]                                   second_class,
    output logic [DATA_WIDTH:0]                          result_margin
`endif
);

    localparam int                    NW        = (NUM_CLASS + DATA_NUM_PER_SRAM_ADDR - 1) / DATA_NUM_PER_SRAM_ADDR;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NW - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]        rword_q, rword_d;
    logic                         rvld_q, rvld_d;
    logic                         best_vld_q, best_vld_d;
    logic signed [DATA_WIDTH-1:0] best_score_q, best_score_d;
    logic [3:0]                   best_class_q, best_class_d;
    logic signed [DATA_WIDTH-1:0] res_score_q, res_score_d;
    logic [3:0]                   res_class_q, res_class_d;
    logic                         scan_start;
    logic signed [DATA_WIDTH-1:0] lane_score [DATA_NUM_PER_SRAM_ADDR];
`ifdef FC_RESULT_SECOND_EN
    logic                         sec_vld_q, sec_vld_d;
    logic signed [DATA_WIDTH-1:0] sec_score_q, sec_score_d;
    logic [3:0]                   sec_class_q, sec_class_d;
    logic [3:0]                   res_sec_q, res_sec_d;
    logic [DATA_WIDTH:0]          res_margin_q, res_margin_d;
`endif

    // Lane 0 sits in the most significant byte of the word.
    genvar gl;
    generate
        for (gl = 0; gl < DATA_NUM_PER_SRAM_ADDR; gl++) begin : g_lane
            assign lane_score[gl] = sram_rdata_f[(DATA_NUM_PER_SRAM_ADDR-1-gl)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign scan_start = fc2_done && ((state_q == ST_IDLE) ||
                                     ((state_q == ST_DONE) && result_ready));

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fc2_done) state_d = ST_READ;
            ST_READ:  if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (result_ready) state_d = fc2_done ? ST_READ : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != ST_IDLE);
        result_valid = (state_q == ST_DONE);
        sram_raddr_f = (state_q == ST_READ) ? addr_q : '0;
        result_class = res_class_q;
        result_score = res_score_q;
`ifdef FC_RESULT_SECOND_EN
        second_class  = res_sec_q;
        result_margin = res_margin_q;
`endif
    end

    always_comb begin
        addr_d       = '0;
        if ((state_q == ST_READ) && (addr_q != LAST_ADDR)) addr_d = addr_q + 1'b1;
        rvld_d       = (state_q == ST_READ);
        rword_d      = addr_q;
        best_vld_d   = best_vld_q;
        best_score_d = best_score_q;
        best_class_d = best_class_q;
        res_score_d  = res_score_q;
        res_class_d  = res_class_q;
`ifdef FC_RESULT_SECOND_EN
        sec_vld_d    = sec_vld_q;
        sec_score_d  = sec_score_q;
        sec_class_d  = sec_class_q;
        res_sec_d    = res_sec_q;
        res_margin_d = res_margin_q;
`endif
        if (scan_start) begin
            best_vld_d   = 1'b0;
            best_score_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            best_class_d = '0;
`ifdef FC_RESULT_SECOND_EN
            sec_vld_d    = 1'b0;
            sec_score_d  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            sec_class_d  = '0;
`endif
        end else if (rvld_q) begin
            // Lanes are visited in ascending class order, so strict compares keep the lowest index on ties.
            for (int l = 0; l < DATA_NUM_PER_SRAM_ADDR; l++) begin
                if ((int'(rword_q) * DATA_NUM_PER_SRAM_ADDR + l) < NUM_CLASS) begin
                    if (!best_vld_d || (lane_score[l] > best_score_d)) begin
`ifdef FC_RESULT_SECOND_EN
                        sec_vld_d   = best_vld_d;
                        sec_score_d = best_score_d;
                        sec_class_d = best_class_d;
`endif
                        best_vld_d   = 1'b1;
                        best_score_d = lane_score[l];
                        best_class_d = 4'(int'(rword_q) * DATA_NUM_PER_SRAM_ADDR + l);
                    end
`ifdef FC_RESULT_SECOND_EN
                    else if (!sec_vld_d || (lane_score[l] > sec_score_d)) begin
                        sec_vld_d   = 1'b1;
                        sec_score_d = lane_score[l];
                        sec_class_d = 4'(int'(rword_q) * DATA_NUM_PER_SRAM_ADDR + l);
                    end
`endif
                end
            end
        end
        // The final word is compared in DRAIN, so results load from the post-compare values.
        if (state_q == ST_DRAIN) begin
            res_score_d = best_score_d;
            res_class_d = best_class_d;
`ifdef FC_RESULT_SECOND_EN
            res_sec_d    = sec_class_d;
            res_margin_d = {best_score_d[DATA_WIDTH-1], best_score_d} -
                           {sec_score_d[DATA_WIDTH-1], sec_score_d};
`endif
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            addr_q       <= '0;
            rword_q      <= '0;
            rvld_q       <= 1'b0;
            best_vld_q   <= 1'b0;
            best_score_q <= '0;
            best_class_q <= '0;
            res_score_q  <= '0;
            res_class_q  <= '0;
`ifdef FC_RESULT_SECOND_EN
            sec_vld_q    <= 1'b0;
            sec_score_q  <= '0;
            sec_class_q  <= '0;
            res_sec_q    <= '0;
            res_margin_q <= '0;
`endif
        end else begin
            addr_q       <= addr_d;
            rword_q      <= rword_d;
            rvld_q       <= rvld_d;
            best_vld_q   <= best_vld_d;
            best_score_q <= best_score_d;
            best_class_q <= best_class_d;
            res_score_q  <= res_score_d;
            res_class_q  <= res_class_d;
`ifdef FC_RESULT_SECOND_EN
            sec_vld_q    <= sec_vld_d;
            sec_score_q  <= sec_score_d;
            sec_class_q  <= sec_class_d;
            res_sec_q    <= res_sec_d;
            res_margin_q <= res_margin_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_result_reader
// Brief    : Directed self-checking bench for fc_result_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_result_reader;

    logic        clk = 1'b0;
    logic        srstn;
    logic        fc2_done;
    logic        result_ready;
    logic [9:0]  sram_raddr_f;
    logic [31:0] sram_rdata_f;
    logic        busy;
    logic        result_valid;
    logic [3:0]  result_class;
    logic [7:0]  result_score;
`ifdef FC_RESULT_SECOND_EN
    logic [3:0]  second_class;
    logic [8:0]  result_margin;
`endif

    logic [31:0] mem [0:3];
    int          sc  [0:11];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fc_result_reader dut (
        .clk          (clk),
        .srstn        (srstn),
        .fc2_done     (fc2_done),
        .sram_raddr_f (sram_raddr_f),
        .sram_rdata_f (sram_rdata_f),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_score (result_score)
`ifdef FC_RESULT_SECOND_EN
        ,
        .second_class (second_class),
        .result_margin(result_margin)
`endif
    );

    // One-cycle registered-read SRAM model.
    always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f[1:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_mem();
        for (int w = 0; w < 3; w++)
            mem[w] = {8'(sc[4*w]), 8'(sc[4*w+1]), 8'(sc[4*w+2]), 8'(sc[4*w+3])};
        mem[3] = '0;
    endtask

    task automatic chk_second(input string tag, input logic [3:0] e2, input logic [8:0] em);
`ifdef FC_RESULT_SECOND_EN
        chk({tag, "_second"}, 32'(second_class), 32'(e2));
        chk({tag, "_margin"}, 32'(result_margin), 32'(em));
`else
        if (e2 > 4'd15 || em > 9'd511) $display("unreachable %s", tag);
`endif
    endtask

    // Starts a scan from IDLE with result_ready held high and checks the full timeline.
    task automatic run_scan(input string tag, input logic [3:0] ec, input logic [7:0] es,
                            input logic [3:0] e2, input logic [8:0] em);
        result_ready = 1'b1;
        fc2_done     = 1'b1;
        tick();
        fc2_done = 1'b0;
        chk({tag, "_t1_addr"}, 32'(sram_raddr_f), 32'd0);
        chk({tag, "_t1_busy"}, 32'(busy), 32'd1);
        chk({tag, "_t1_valid"}, 32'(result_valid), 32'd0);
        tick();
        chk({tag, "_t2_addr"}, 32'(sram_raddr_f), 32'd1);
        tick();
        chk({tag, "_t3_addr"}, 32'(sram_raddr_f), 32'd2);
        tick();
        chk({tag, "_t4_valid"}, 32'(result_valid), 32'd0);
        tick();
        chk({tag, "_t5_valid"}, 32'(result_valid), 32'd1);
        chk({tag, "_class"}, 32'(result_class), 32'(ec));
        chk({tag, "_score"}, 32'(result_score), 32'(es));
        chk_second(tag, e2, em);
        tick();
        chk({tag, "_t6_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_t6_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        srstn        = 1'b0;
        fc2_done     = 1'b0;
        result_ready = 1'b0;
        sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        pack_mem();
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_addr", 32'(sram_raddr_f), 32'd0);
        chk("rst_class", 32'(result_class), 32'd0);
        chk("rst_score", 32'(result_score), 32'd0);
        chk_second("rst", 4'd0, 9'd0);
        srstn = 1'b1;
        tick();

        // Distinct scores: 90 at class 4, 89 at class 8.
        sc = '{3, -5, 17, 0, 90, 12, -128, 44, 89, 1, 0, 0};
        pack_mem();
        run_scan("distinct", 4'd4, 8'h5A, 4'd8, 9'd1);

        // All equal at the minimum score.
        sc = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, 0, 0};
        pack_mem();
        run_scan("equal", 4'd0, 8'h80, 4'd1, 9'd0);

        // Masked lanes hold 127; real maximum 5 is tied between classes 2 and 9.
        sc = '{1, 2, 5, -3, 0, 4, -7, 3, 2, 5, 127, 127};
        pack_mem();
        run_scan("masked", 4'd2, 8'h05, 4'd9, 9'd0);

        // Backpressure with an ignored second fc2_done.
        sc = '{10, 20, 30, 40, -1, -2, 50, 49, 0, 0, 0, 0};
        pack_mem();
        result_ready = 1'b0;
        fc2_done     = 1'b1;
        tick();
        fc2_done = 1'b0;
        repeat (4) tick();
        chk("bp_valid", 32'(result_valid), 32'd1);
        chk("bp_class", 32'(result_class), 32'd6);
        for (int i = 0; i < 20; i++) begin
            fc2_done = (i == 5);
            tick();
            chk("bp_hold_valid", 32'(result_valid), 32'd1);
            chk("bp_hold_class", 32'(result_class), 32'd6);
            chk("bp_hold_score", 32'(result_score), 32'd50);
            chk("bp_hold_addr", 32'(sram_raddr_f), 32'd0);
        end
        fc2_done = 1'b0;
        chk_second("bp", 4'd7, 9'd1);
        result_ready = 1'b1;
        chk("bp_acc_busy", 32'(busy), 32'd1);
        tick();
        result_ready = 1'b0;
        chk("bp_after_busy", 32'(busy), 32'd0);
        chk("bp_after_valid", 32'(result_valid), 32'd0);
        tick();
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // Accept coincident with fc2_done restarts immediately on new contents.
        sc = '{3, -5, 17, 0, 90, 12, -128, 44, 89, 1, 0, 0};
        pack_mem();
        fc2_done = 1'b1;
        tick();
        fc2_done = 1'b0;
        repeat (4) tick();
        chk("rs_first_valid", 32'(result_valid), 32'd1);
        chk("rs_first_class", 32'(result_class), 32'd4);
        sc = '{0, 0, 0, 0, 0, 0, 0, 100, -100, 99, 0, 0};
        pack_mem();
        result_ready = 1'b1;
        fc2_done     = 1'b1;
        tick();
        result_ready = 1'b0;
        fc2_done     = 1'b0;
        chk("rs_a1_busy", 32'(busy), 32'd1);
        chk("rs_a1_valid", 32'(result_valid), 32'd0);
        chk("rs_a1_addr", 32'(sram_raddr_f), 32'd0);
        chk("rs_a1_class_held", 32'(result_class), 32'd4);
        repeat (3) tick();
        chk("rs_a4_valid", 32'(result_valid), 32'd0);
        tick();
        chk("rs_a5_valid", 32'(result_valid), 32'd1);
        chk("rs_class", 32'(result_class), 32'd7);
        chk("rs_score", 32'(result_score), 32'd100);
        chk_second("rs", 4'd9, 9'd1);
        result_ready = 1'b1;
        tick();
        chk("rs_done_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a scan.
        sc = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 7, 0, 0};
        pack_mem();
        fc2_done = 1'b1;
        tick();
        fc2_done = 1'b0;
        tick();
        tick();
        srstn = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(result_valid), 32'd0);
        chk("mrst_addr", 32'(sram_raddr_f), 32'd0);
        chk("mrst_class", 32'(result_class), 32'd0);
        chk("mrst_score", 32'(result_score), 32'd0);
        chk_second("mrst", 4'd0, 9'd0);
        tick();
        srstn = 1'b1;
        tick();
        run_scan("postrst", 4'd9, 8'h07, 4'd0, 9'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_result_reader.md
# fc_result_reader

Reads the ten FC2 class scores from SRAM f once the FC stage reports `fc2_done`, and computes the signed argmax, which is the predicted digit. It presents that digit and its score on a valid/ready result port. It sits downstream of the FC datapath, which writes SRAM f, and acts as the reader at the far end of that SRAM. Its result port feeds the accelerator's host or status interface.

## Interface
- `DATA_WIDTH`, 8: bits per score; scores are signed two's complement.
- `DATA_NUM_PER_SRAM_ADDR`, 4: scores packed per SRAM f word.
- `NUM_CLASS`, 10: number of scores to scan; must be ≤ 16.
- `ADDR_WIDTH`, 10: SRAM f address width.

- `clk`  in  1  rising-edge clock.
- `srstn`  in  1  reset, asynchronous, active-low.
- `fc2_done`  in  1  single-cycle pulse; SRAM f holds a complete score set.
- `sram_raddr_f`  out  ADDR_WIDTH  SRAM f read address.
- `sram_rdata_f`  in  DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH  SRAM f read data, one-cycle registered latency.
- `busy`  out  1  high from scan start until result accepted.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.
- `result_class`  out  4  winning class index.
- `result_score`  out  DATA_WIDTH  winning score, signed.
- `second_class`  out  4  runner-up index. Present only with `FC_RESULT_SECOND_EN`.
- `result_margin`  out  DATA_WIDTH+1  winning score minus runner-up score, unsigned. Present only with `FC_RESULT_SECOND_EN`.

## Operation
- **Score layout:** score k is in word k/4, byte lane k%4. Lane 0 is `[31:24]` and lane 3 is `[7:0]`. NW = ceil(NUM_CLASS/4) = 3 words, at addresses 0 to 2.
- **IDLE:** `busy` = 0 and `sram_raddr_f` = 0. `fc2_done` moves the block to READ.
- **READ:** issues one address per cycle, 0 to NW-1. It then moves to DRAIN.
- **DRAIN:** absorbs the last read word, then moves to DONE.
- **Scan datapath:** each returned word is compared lane by lane against the running best.
  - The running best initialises to score −128 with class 0.
  - An update needs a strictly greater score, so ties resolve to the lowest index.
  - Lanes whose index is ≥ NUM_CLASS (indices 10 and 11 in word 2) are masked and never win.
- **DONE:** `result_valid` = 1 and all result outputs are stable. When `result_valid` && `result_ready`, the block returns to IDLE.
- **Accept and restart:** if `fc2_done` arrives in the same cycle as acceptance, the block goes directly to READ with the running best re-initialised.
- **`fc2_done` while in READ, DRAIN or DONE without acceptance:** ignored. The current scan or result is unaffected.
- **Reset, including mid-scan:** all state returns to IDLE.
  - `sram_raddr_f` = 0, `busy` = 0, `result_valid` = 0.
  - `result_class` = 0, `result_score` = 0, `second_class` = 0, `result_margin` = 0.

## Timing
- `fc2_done` is sampled high at cycle T. `sram_raddr_f` is 0, 1 and 2 at cycles T+1, T+2 and T+3.
- Read data arrives at T+2, T+3 and T+4. The last compare registers at the end of T+4.
- `result_valid` rises at T+5, so latency is 5 cycles for NUM_CLASS = 10. In general latency is NW+2.
- `busy` rises at T+1 and falls in the cycle after acceptance.
- Result outputs change only while loading DONE. They are held until acceptance, even when `result_ready` stays low indefinitely.
- Back-to-back operation: acceptance coinciding with `fc2_done` at cycle A gives the next `result_valid` at A+5.

## Configuration
- **`FC_RESULT_SECOND_EN` defined:**
  - Also tracks the runner-up. It takes the best score among all non-winning classes, with ties going to the lowest index.
  - `second_class` and `result_margin` are exported and are valid with `result_valid`.
  - The margin is computed in DATA_WIDTH+1 bits (0 to 255). Equal top scores give margin 0, with `second_class` set to the higher of the tied indices.
- **Not defined:** the runner-up logic and both ports are absent. Argmax behaviour and timing are identical.

## Test plan
- **Distinct scores:** scores {3, −5, 17, 0, 90, 12, −128, 44, 89, 1}, `result_ready` tied high. Expect `result_valid` at T+5 for exactly one cycle, class 4, score 90. With the macro: second class 8, margin 1.
- **All equal:** all scores −128. Expect class 0 and score −128. With the macro: second class 1, margin 0.
- **Masked lanes and tie:** word 2 lanes 2 and 3 are 127, while real scores max at class 9 = 5 and class 2 = 5. Expect class 2 and score 5; the masked lanes are ignored.
- **Backpressure and double pulse:** `result_ready` low for 20 cycles after valid, with a second `fc2_done` pulsed during the hold. Expect the result held unchanged, the pulse ignored, and `busy` falling one cycle after `result_ready` rises.
- **Accept and restart:** `fc2_done` coincident with acceptance, SRAM contents changed so class 7 wins. Expect the new `result_valid` 5 cycles later with class 7.
- **Reset mid-scan:** `srstn` low at T+3. Expect all outputs 0 immediately. A following `fc2_done` gives a correct result 5 cycles later.
